// File: rtl/sync_fifo_unpack_if.sv
// Bus bundle for sync_fifo_unpack: word-wide write side, lane-wide read side.
// Handshake: a write is taken on a rising edge with wr_en high and full low; a lane read is taken with rd_en high and empty low, dout/dout_valid follow one edge later.
interface sync_fifo_unpack_if #(
  parameter int WR_WIDTH = 32,
  parameter int RD_WIDTH = 8,
  parameter int DEPTH    = 256
) ();
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int RATIO      = WR_WIDTH / RD_WIDTH;
  localparam int ADDR_WIDTH = clogb2(DEPTH);
  localparam int LANE_W     = clogb2(RATIO + 1);

  logic                  wr_en;
  logic [WR_WIDTH-1:0]   din;
  logic [LANE_W-1:0]     din_lanes;
  logic                  full;
  logic                  overflow;
  logic                  rd_en;
  logic [RD_WIDTH-1:0]   dout;
  logic                  dout_valid;
  logic                  empty;
  logic [ADDR_WIDTH:0]   word_cnt;

  modport master (
    output wr_en, din, din_lanes, rd_en,
    input  full, overflow, dout, dout_valid, empty, word_cnt
  );

  modport slave (
    input  wr_en, din, din_lanes, rd_en,
    output full, overflow, dout, dout_valid, empty, word_cnt
  );
endinterface

// File: rtl/sync_fifo_unpack.sv
// Word-in / lane-out FIFO: stores wide words with a lane count and emits them
// MSB lane first through a single unpack register, one lane per cycle.
module sync_fifo_unpack #(
  parameter int WR_WIDTH = 32,
  parameter int RD_WIDTH = 8,
  parameter int DEPTH    = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  sync_fifo_unpack_if.slave bus
);
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int RATIO      = WR_WIDTH / RD_WIDTH;
  localparam int ADDR_WIDTH = clogb2(DEPTH);
  localparam int LANE_W     = clogb2(RATIO + 1);
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int ENT_W      = WR_WIDTH + LANE_W;

  logic [ENT_W-1:0]      mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [WR_WIDTH-1:0]   cur_word_q, cur_word_d;
  logic [LANE_W-1:0]     cur_left_q, cur_left_d;
  logic [RD_WIDTH-1:0]   dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overflow_q, overflow_d;

  logic                  full, empty;
  logic                  wr_accept, rd_fire, load;
  logic [LANE_W-1:0]     eff_lanes;
  logic [ENT_W-1:0]      rd_entry;

  assign full  = (word_cnt_q == CNT_W'(DEPTH));
  assign empty = (cur_left_q == '0);

  // Out-of-range lane counts (0 or above RATIO) mean a whole word.
  assign eff_lanes = ((bus.din_lanes == '0) || (bus.din_lanes > LANE_W'(RATIO)))
                     ? LANE_W'(RATIO) : bus.din_lanes;

  assign wr_accept = !clr && bus.wr_en && !full;
  assign rd_fire   = !clr && bus.rd_en && !empty;
  // Refill when idle, or on the edge that consumes the last lane so the stream has no bubble.
  assign load      = !clr && (word_cnt_q != '0) &&
                     ((cur_left_q == '0) || (bus.rd_en && (cur_left_q == LANE_W'(1))));
  assign rd_entry  = mem[rd_addr_q];

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr_q] <= {bus.din, eff_lanes};
  end

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    word_cnt_d   = word_cnt_q;
    cur_word_d   = cur_word_q;
    cur_left_d   = cur_left_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    if (clr) begin
      wr_addr_d  = '0;
      rd_addr_d  = '0;
      word_cnt_d = '0;
      cur_left_d = '0;
    end else begin
      overflow_d   = bus.wr_en && full;
      dout_valid_d = rd_fire;
      if (wr_accept) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      if (rd_fire) begin
        dout_d     = cur_word_q[WR_WIDTH-1 -: RD_WIDTH];
        cur_word_d = cur_word_q << RD_WIDTH;
        cur_left_d = cur_left_q - LANE_W'(1);
      end
      if (load) begin
        cur_word_d = rd_entry[ENT_W-1 -: WR_WIDTH];
        cur_left_d = rd_entry[LANE_W-1:0];
        rd_addr_d  = rd_addr_q + ADDR_WIDTH'(1);
      end
      case ({wr_accept, load})
        2'b10:   word_cnt_d = word_cnt_q + CNT_W'(1);
        2'b01:   word_cnt_d = word_cnt_q - CNT_W'(1);
        default: word_cnt_d = word_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      word_cnt_q   <= '0;
      cur_word_q   <= '0;
      cur_left_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      word_cnt_q   <= word_cnt_d;
      cur_word_q   <= cur_word_d;
      cur_left_q   <= cur_left_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_sync_fifo_unpack.sv
// Directed bench for sync_fifo_unpack with DEPTH=4 so full and wrap are reachable.
module tb_sync_fifo_unpack;
  logic clk;
  logic rst_n;
  logic clr;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  sync_fifo_unpack_if #(.WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(4)) bus ();

  sync_fifo_unpack #(.WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = '0; bus.din_lanes = '0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    vec_cnt++; if (bus.dout !== 8'h00) begin err_cnt++; $display("FAIL reset_dout got %h exp 00", bus.dout); end
    vec_cnt++; if (bus.dout_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_dout_valid got %b exp 0", bus.dout_valid); end
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    vec_cnt++; if (bus.word_cnt !== 3'd0) begin err_cnt++; $display("FAIL reset_word_cnt got %0d exp 0", bus.word_cnt); end
    vec_cnt++; if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    vec_cnt++; if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL reset_full got %b exp 0", bus.full); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    bus.wr_en = 1'b1; bus.din = 32'hA1B2C3D4; bus.din_lanes = 3'd0;
    tick();
    bus.wr_en = 1'b0;
    vec_cnt++; if (bus.word_cnt !== 3'd1) begin err_cnt++; $display("FAIL basic_cnt_after_write got %0d exp 1", bus.word_cnt); end
    vec_cnt++; if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL basic_empty_after_write got %b exp 1", bus.empty); end
    tick();
    vec_cnt++; if (bus.empty !== 1'b0) begin err_cnt++; $display("FAIL basic_empty_after_load got %b exp 0", bus.empty); end
    vec_cnt++; if (bus.word_cnt !== 3'd0) begin err_cnt++; $display("FAIL basic_cnt_after_load got %0d exp 0", bus.word_cnt); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      vec_cnt++; if (bus.dout !== e || bus.dout_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_lane%0d got %h/%b exp %h/1", i, bus.dout, bus.dout_valid, e); end
    end
    vec_cnt++; if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL basic_empty_end got %b exp 1", bus.empty); end
    tick();
    vec_cnt++; if (bus.dout_valid !== 1'b0 || bus.dout !== 8'hD4) begin err_cnt++; $display("FAIL basic_idle_read got %h/%b exp d4/0", bus.dout, bus.dout_valid); end
    idle_inputs();
  endtask

  task automatic test_partial();
    logic [7:0] exp_q[$];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b1; bus.din = 32'h1122_0000; bus.din_lanes = 3'd2;
    tick();
    bus.din = 32'h33445566; bus.din_lanes = 3'd4;
    tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      vec_cnt++; if (bus.dout !== e || bus.dout_valid !== 1'b1) begin err_cnt++; $display("FAIL partial_lane%0d got %h/%b exp %h/1", i, bus.dout, bus.dout_valid, e); end
    end
    vec_cnt++; if (bus.empty !== 1'b1 || bus.word_cnt !== 3'd0) begin err_cnt++; $display("FAIL partial_end got empty=%b cnt=%0d exp 1/0", bus.empty, bus.word_cnt); end
    idle_inputs();
  endtask

  task automatic test_full_overflow();
    for (int k = 0; k < 6; k++) begin
      bus.wr_en = 1'b1;
      bus.din = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      bus.din_lanes = 3'd0;
      tick();
      vec_cnt++; if (bus.overflow !== (k == 5)) begin err_cnt++; $display("FAIL full_overflow_w%0d got %b exp %b", k, bus.overflow, (k == 5)); end
    end
    bus.wr_en = 1'b0;
    tick();
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL full_overflow_drop got %b exp 0", bus.overflow); end
    vec_cnt++; if (bus.word_cnt !== 3'd4) begin err_cnt++; $display("FAIL full_word_cnt got %0d exp 4", bus.word_cnt); end
    vec_cnt++; if (bus.full !== 1'b1) begin err_cnt++; $display("FAIL full_flag got %b exp 1", bus.full); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vec_cnt++; if (bus.dout !== 8'(i) || bus.dout_valid !== 1'b1) begin err_cnt++; $display("FAIL full_drain%0d got %h/%b exp %h/1", i, bus.dout, bus.dout_valid, 8'(i)); end
    end
    bus.rd_en = 1'b0;
    vec_cnt++; if (bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.word_cnt !== 3'd0) begin err_cnt++; $display("FAIL full_drain_end got full=%b empty=%b cnt=%0d exp 0/1/0", bus.full, bus.empty, bus.word_cnt); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    for (int k = 0; k < 10; k++) for (int j = 0; j < 4; j++) exp_q.push_back(8'(k));
    while (got < 40 && cyc < 300) begin
      bus.wr_en = (sent < 10) && !bus.full;
      bus.din = {4{8'(sent)}};
      bus.din_lanes = 3'd0;
      bus.rd_en = (cyc % 3) != 2;
      tick();
      cyc++;
      if (bus.wr_en) sent++;
      if (bus.dout_valid) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        vec_cnt++; if (bus.dout !== e) begin err_cnt++; $display("FAIL wrap_lane%0d got %h exp %h", got, bus.dout, e); end
        got++;
      end
    end
    idle_inputs();
    vec_cnt++; if (got != 40) begin err_cnt++; $display("FAIL wrap_timeout got %0d lanes exp 40", got); end
    vec_cnt++; if (bus.word_cnt !== 3'd0 || bus.empty !== 1'b1) begin err_cnt++; $display("FAIL wrap_end got cnt=%0d empty=%b exp 0/1", bus.word_cnt, bus.empty); end
  endtask

  task automatic test_empty_read();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    vec_cnt++; if (bus.dout !== 8'h09 || bus.dout_valid !== 1'b0) begin err_cnt++; $display("FAIL empty_read got %h/%b exp 09/0", bus.dout, bus.dout_valid); end
    vec_cnt++; if (bus.word_cnt !== 3'd0 || bus.empty !== 1'b1) begin err_cnt++; $display("FAIL empty_read_state got cnt=%0d empty=%b exp 0/1", bus.word_cnt, bus.empty); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q[$];
    exp_q = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    bus.wr_en = 1'b1; bus.din = 32'h5500_0000; bus.din_lanes = 3'd1;
    tick();
    bus.din = 32'h6600_0000; bus.din_lanes = 3'd1;
    tick();
    bus.wr_en = 1'b0;
    vec_cnt++; if (bus.word_cnt !== 3'd1 || bus.empty !== 1'b0) begin err_cnt++; $display("FAIL simul_setup got cnt=%0d empty=%b exp 1/0", bus.word_cnt, bus.empty); end
    // Lane count 5 exceeds RATIO and must act as a full word.
    bus.wr_en = 1'b1; bus.din = 32'h778899AA; bus.din_lanes = 3'd5; bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    vec_cnt++; if (bus.word_cnt !== 3'd1) begin err_cnt++; $display("FAIL simul_word_cnt got %0d exp 1", bus.word_cnt); end
    vec_cnt++; if (bus.dout !== 8'h55 || bus.dout_valid !== 1'b1) begin err_cnt++; $display("FAIL simul_last_lane got %h/%b exp 55/1", bus.dout, bus.dout_valid); end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      vec_cnt++; if (bus.dout !== e || bus.dout_valid !== 1'b1) begin err_cnt++; $display("FAIL simul_lane%0d got %h/%b exp %h/1", i, bus.dout, bus.dout_valid, e); end
    end
    vec_cnt++; if (bus.empty !== 1'b1 || bus.word_cnt !== 3'd0) begin err_cnt++; $display("FAIL simul_end got empty=%b cnt=%0d exp 1/0", bus.empty, bus.word_cnt); end
    idle_inputs();
  endtask

  task automatic test_clear();
    logic [7:0] exp_q[$];
    exp_q = '{8'hCA, 8'hFE, 8'hF0};
    bus.wr_en = 1'b1; bus.din = 32'hDEADBEEF; bus.din_lanes = 3'd0;
    tick();
    bus.din = 32'h01020304;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    tick();
    vec_cnt++; if (bus.dout !== 8'hDE) begin err_cnt++; $display("FAIL clr_pre_lane got %h exp de", bus.dout); end
    clr = 1'b1; bus.wr_en = 1'b1; bus.din = 32'hFFFFFFFF; bus.rd_en = 1'b1;
    tick();
    clr = 1'b0;
    vec_cnt++; if (bus.empty !== 1'b1 || bus.word_cnt !== 3'd0) begin err_cnt++; $display("FAIL clr_state got empty=%b cnt=%0d exp 1/0", bus.empty, bus.word_cnt); end
    vec_cnt++; if (bus.dout !== 8'hDE || bus.dout_valid !== 1'b0) begin err_cnt++; $display("FAIL clr_dout got %h/%b exp de/0", bus.dout, bus.dout_valid); end
    bus.wr_en = 1'b1; bus.din = 32'hCAFEF00D; bus.din_lanes = 3'd3; bus.rd_en = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    tick();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tick();
      vec_cnt++; if (bus.dout !== e || bus.dout_valid !== 1'b1) begin err_cnt++; $display("FAIL clr_lane%0d got %h/%b exp %h/1", i, bus.dout, bus.dout_valid, e); end
    end
    tick();
    vec_cnt++; if (bus.dout_valid !== 1'b0 || bus.empty !== 1'b1) begin err_cnt++; $display("FAIL clr_end got valid=%b empty=%b exp 0/1", bus.dout_valid, bus.empty); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      bus.wr_en = 1'b1;
      bus.din = {8'(8'h81 + 4*k), 8'(8'h82 + 4*k), 8'(8'h83 + 4*k), 8'(8'h84 + 4*k)};
      bus.din_lanes = 3'd0;
      tick();
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    tick();
    vec_cnt++; if (bus.dout !== 8'h81 || bus.word_cnt !== 3'd3) begin err_cnt++; $display("FAIL arst_pre got dout=%h cnt=%0d exp 81/3", bus.dout, bus.word_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL arst_outputs got dout=%h valid=%b ovf=%b exp 00/0/0", bus.dout, bus.dout_valid, bus.overflow); end
    vec_cnt++; if (bus.word_cnt !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin err_cnt++; $display("FAIL arst_flags got cnt=%0d empty=%b full=%b exp 0/1/0", bus.word_cnt, bus.empty, bus.full); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++; if (bus.dout_valid !== 1'b0 || bus.empty !== 1'b1) begin err_cnt++; $display("FAIL arst_after%0d got valid=%b empty=%b exp 0/1", i, bus.dout_valid, bus.empty); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full_overflow();
    test_wrap();
    test_empty_read();
    test_simultaneous();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
